bus_arbiter: RTL and testbench

- Shares the single tristate `sysbus` and the ram/rom chip-select path between two requesters: the CPU (sequencer-driven fetch/execute traffic) and a DMA/IO engine that moves `switches`/`display` data.
- Issues mutually exclusive registered grants with round-robin fairness.
- Inserts a one-cycle turnaround between owners to prevent bus contention.
- Forcibly preempts an owner that holds the bus past a limit while the other requester waits.
- Sits at cpu2 top level beside the sequencer; the grants gate each side's `CS` and bus drivers.

---
 rtl/bus_arbiter.sv | 99 +++++++++
 tb/tb_bus_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester round-robin bus arbiter with turnaround and hold-limit preemption
module bus_arbiter #(
    parameter int WORD_W   = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_done,
    input  logic              dma_req,
    input  logic              dma_done,
    output logic              cpu_gnt,
    output logic              dma_gnt,
    output logic              cpu_stall,
    output logic              preempt,
    output logic [WORD_W-1:0] preempt_cnt
);

    typedef enum logic [1:0] {IDLE, CPU_OWN, DMA_OWN, TURN} state_t;

    localparam logic [7:0]        HOLD_LIM = 8'(MAX_HOLD - 1);
    localparam logic [WORD_W-1:0] CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic              last_dma_q, last_dma_d;
    logic              preempt_q, preempt_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;

    logic own_is_cpu;
    logic own_req;
    logic own_done;
    logic other_req;

    assign own_is_cpu = (state_q == CPU_OWN);
    assign own_req    = own_is_cpu ? cpu_req  : dma_req;
    assign own_done   = own_is_cpu ? cpu_done : dma_done;
    assign other_req  = own_is_cpu ? dma_req  : cpu_req;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        last_dma_d = last_dma_q;
        preempt_d  = 1'b0;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE, TURN: begin
                hold_d = '0;
                // On a tie the side that did not own last gets the bus
                if (cpu_req && (!dma_req || last_dma_q)) begin
                    state_d    = CPU_OWN;
                    last_dma_d = 1'b0;
                end else if (dma_req) begin
                    state_d    = DMA_OWN;
                    last_dma_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CPU_OWN, DMA_OWN: begin
                if (own_done || !own_req) begin
                    state_d = TURN;
                end else if (hold_q == HOLD_LIM && other_req) begin
                    state_d   = TURN;
                    preempt_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + WORD_W'(1);
                    end
                end else if (hold_q != HOLD_LIM) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            last_dma_q <= 1'b1;
            preempt_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            last_dma_q <= last_dma_d;
            preempt_q  <= preempt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cpu_gnt     = (state_q == CPU_OWN);
    assign dma_gnt     = (state_q == DMA_OWN);
    assign preempt     = preempt_q;
    assign preempt_cnt = cnt_q;
    assign cpu_stall   = cpu_req & ~cpu_gnt;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter
module tb_bus_arbiter;

    localparam int MH = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_done = 1'b0;
    logic       dma_req = 1'b0;
    logic       dma_done = 1'b0;
    logic       cpu_gnt;
    logic       dma_gnt;
    logic       cpu_stall;
    logic       preempt;
    logic [7:0] preempt_cnt;

    always #5 clock = ~clock;

    bus_arbiter #(.WORD_W(8), .MAX_HOLD(MH)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_done   (cpu_done),
        .dma_req    (dma_req),
        .dma_done   (dma_done),
        .cpu_gnt    (cpu_gnt),
        .dma_gnt    (dma_gnt),
        .cpu_stall  (cpu_stall),
        .preempt    (preempt),
        .preempt_cnt(preempt_cnt)
    );

    typedef struct {
        logic       cg;
        logic       dg;
        logic       pre;
        logic [7:0] cnt;
        logic       stall;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: 0 idle, 1 cpu owns, 2 dma owns, 3 turnaround
    int m_st = 0;
    int m_hold = 0;
    int m_last_dma = 1;
    int m_pre = 0;
    int m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit rst, input bit cr, input bit cd, input bit dr, input bit dd);
        bit mine_req, mine_done, other;
        if (rst) begin
            m_st = 0; m_hold = 0; m_last_dma = 1; m_pre = 0; m_cnt = 0;
        end else if (m_st == 0 || m_st == 3) begin
            m_pre = 0;
            m_hold = 0;
            if (cr && dr) m_st = (m_last_dma != 0) ? 1 : 2;
            else if (cr)  m_st = 1;
            else if (dr)  m_st = 2;
            else          m_st = 0;
            if (m_st == 1) m_last_dma = 0;
            if (m_st == 2) m_last_dma = 1;
        end else begin
            mine_req  = (m_st == 1) ? cr : dr;
            mine_done = (m_st == 1) ? cd : dd;
            other     = (m_st == 1) ? dr : cr;
            m_pre = 0;
            if (mine_done || !mine_req) begin
                m_st = 3;
            end else if (m_hold == MH - 1 && other) begin
                m_st = 3;
                m_pre = 1;
                if (m_cnt < 255) m_cnt++;
            end else if (m_hold < MH - 1) begin
                m_hold++;
            end
        end
    endtask

    task automatic step(input bit rst, input bit cr, input bit cd, input bit dr, input bit dd);
        exp_t e;
        exp_t g;
        @(negedge clock);
        reset = rst; cpu_req = cr; cpu_done = cd; dma_req = dr; dma_done = dd;
        model(rst, cr, cd, dr, dd);
        e.cg    = (m_st == 1);
        e.dg    = (m_st == 2);
        e.pre   = (m_pre != 0);
        e.cnt   = 8'(m_cnt);
        e.stall = cr && (m_st != 1);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        g = sb_q.pop_front();
        check("cpu_gnt", 32'(cpu_gnt), 32'(g.cg));
        check("dma_gnt", 32'(dma_gnt), 32'(g.dg));
        check("preempt", 32'(preempt), 32'(g.pre));
        check("preempt_cnt", 32'(preempt_cnt), 32'(g.cnt));
        check("cpu_stall", 32'(cpu_stall), 32'(g.stall));
        check("exclusive", 32'(cpu_gnt & dma_gnt), 32'd0);
    endtask

    initial begin
        int own;
        int bad;
        bit cd;
        bit dd;

        // Reset with both requesting, then CPU wins the first tie
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        check("rst_cnt", 32'(preempt_cnt), 32'd0);
        step(0, 1, 0, 1, 0);
        check("first_tie_cpu", 32'(cpu_gnt), 32'd1);
        check("first_tie_dma", 32'(dma_gnt), 32'd0);

        // Lone DMA request: four owned cycles then turnaround on done
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0);
            check("single_dma_gnt", 32'(dma_gnt), 32'd1);
        end
        step(0, 0, 0, 1, 1);
        check("single_turn_gnt", 32'(dma_gnt), 32'd0);
        check("single_turn_pre", 32'(preempt), 32'd0);
        step(0, 0, 0, 0, 0);

        // Tie traffic: owner pulses done in its third owned cycle
        for (int i = 0; i < 24; i++) begin
            cd = (m_st == 1 && m_hold == 2);
            dd = (m_st == 2 && m_hold == 2);
            step(0, 1, cd, 1, dd);
        end

        // Preemption after eight owned cycles
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        own = 2;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 1, 0);
            if (cpu_gnt) own++;
            else break;
        end
        check("preempt_hold_len", 32'(own), 32'd8);
        check("preempt_pulse", 32'(preempt), 32'd1);
        check("preempt_cnt_one", 32'(preempt_cnt), 32'd1);
        step(0, 1, 0, 1, 0);
        check("preempt_dma_follows", 32'(dma_gnt), 32'd1);
        check("preempt_one_cycle", 32'(preempt), 32'd0);

        // Keep both contending until the counter saturates
        for (int i = 0; i < 300 * 9; i++) begin
            step(0, 1, 0, 1, 0);
        end
        check("cnt_saturated", 32'(preempt_cnt), 32'd255);

        // Uncontended CPU hold
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(0, 1, 0, 0, 0);
            if (!cpu_gnt || preempt) bad++;
        end
        check("uncontended_hold", 32'(bad), 32'd0);
        check("uncontended_cnt", 32'(preempt_cnt), 32'd255);

        // Reset while DMA owns
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("mid_rst_dma_owns", 32'(dma_gnt), 32'd1);
        step(1, 0, 0, 1, 0);
        check("mid_rst_dma_gnt", 32'(dma_gnt), 32'd0);
        check("mid_rst_pre", 32'(preempt), 32'd0);
        check("mid_rst_cnt", 32'(preempt_cnt), 32'd0);

        // Done coinciding with the hold limit is a normal release
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 1, 0);
        end
        check("limit_cpu_owns", 32'(cpu_gnt), 32'd1);
        step(0, 1, 1, 1, 0);
        check("limit_done_gnt", 32'(cpu_gnt | dma_gnt), 32'd0);
        check("limit_done_pre", 32'(preempt), 32'd0);
        check("limit_done_cnt", 32'(preempt_cnt), 32'd0);
        step(0, 0, 0, 1, 0);
        check("limit_dma_next", 32'(dma_gnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
